oh_gpio_ctrl: RTL

- Core-side controller for one padring side's GPIO bank.
- Drives the pad-facing dout/oen/ie/cfg bundle; samples and synchronizes din.
- Detects per-pad edges and raises a maskable interrupt.
- Exposes a simple memory-mapped register port to the core bus.

---
 rtl/oh_gpio_pkg.sv | 22 ++
 rtl/oh_dsync.sv | 27 ++
 rtl/oh_gpio_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/oh_gpio_pkg.sv
// rtl/oh_gpio_pkg.sv - register offsets and width constants for the GPIO bank controller
package oh_gpio_pkg;

   localparam int REG_AW = 8;
   localparam int REG_DW = 32;

   localparam logic [REG_AW-1:0] GPIO_DOUT       = 8'h00;
   localparam logic [REG_AW-1:0] GPIO_OEN        = 8'h04;
   localparam logic [REG_AW-1:0] GPIO_IE         = 8'h08;
   localparam logic [REG_AW-1:0] GPIO_DIN        = 8'h0C;
   localparam logic [REG_AW-1:0] GPIO_IRQ_EN     = 8'h10;
   localparam logic [REG_AW-1:0] GPIO_IRQ_POL    = 8'h14;
   localparam logic [REG_AW-1:0] GPIO_IRQ_STATUS = 8'h18;
   localparam logic [REG_AW-1:0] GPIO_DOUT_SET   = 8'h1C;
   localparam logic [REG_AW-1:0] GPIO_DOUT_CLR   = 8'h20;
   localparam logic [REG_AW-1:0] GPIO_CFG_BASE   = 8'h40;

   function automatic logic [REG_AW-1:0] cfg_addr(input int k);
      return GPIO_CFG_BASE + REG_AW'(4 * k);
   endfunction

endpackage

// File: rtl/oh_dsync.sv
// rtl/oh_dsync.sv - SYNC-deep synchronizer, W bits wide
module oh_dsync #(
   parameter int W    = 1,
   parameter int SYNC = 2
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [SYNC-1:0][W-1:0] sync_q, sync_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = din;
      for (int i = 1; i < SYNC; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sync_q <= '0;
      else         sync_q <= sync_d;
   end

   assign dout = sync_q[SYNC-1];

endmodule

// File: rtl/oh_gpio_ctrl.sv
// rtl/oh_gpio_ctrl.sv - GPIO bank controller: register file, din sync, edge detect, irq
module oh_gpio_ctrl
   import oh_gpio_pkg::*;
#(
   parameter int N    = 8,
   parameter int CFGW = 8,
   parameter int SYNC = 2
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                reg_access,
   input  logic                reg_write,
   input  logic [REG_AW-1:0]   reg_addr,
   input  logic [REG_DW-1:0]   reg_wdata,
   output logic [REG_DW-1:0]   reg_rdata,
   output logic                reg_rvalid,
   input  logic [N-1:0]        gpio_din,
   output logic [N-1:0]        gpio_dout,
   output logic [N-1:0]        gpio_oen,
   output logic [N-1:0]        gpio_ie,
   output logic [N*CFGW-1:0]   gpio_cfg,
   output logic                irq
);

   logic [N-1:0]           dout_q, dout_d, oen_q, oen_d, ie_q, ie_d, ie_prev_q;
   logic [N-1:0]           irq_en_q, irq_en_d, irq_pol_q, irq_pol_d;
   logic [N-1:0]           status_q, status_d, prev_q;
   logic [N-1:0][CFGW-1:0] cfg_q, cfg_d;
   logic [REG_DW-1:0]      rdata_q, rdata_d, rdata_mux;
   logic                   rvalid_q, rvalid_d, irq_q, irq_d;
   logic [N-1:0]           sync_out, din_s, evt, w1c, wdata_n;
   logic                   wr, rd;
   logic                   unused_wdata;

   assign unused_wdata = ^reg_wdata;

   oh_dsync #(.W(N), .SYNC(SYNC)) u_dsync (
      .clk    (clk),
      .nreset (nreset),
      .din    (gpio_din),
      .dout   (sync_out)
   );

   assign din_s = sync_out & ie_q;

   // ie_prev_q gates out the edge that enabling/disabling the input itself would fake
   assign evt = ((irq_pol_q & din_s & ~prev_q) | (~irq_pol_q & ~din_s & prev_q))
                & ie_q & ie_prev_q;

   assign wr      = reg_access & reg_write;
   assign rd      = reg_access & ~reg_write;
   assign wdata_n = reg_wdata[N-1:0];

   always_comb begin
      dout_d    = dout_q;
      oen_d     = oen_q;
      ie_d      = ie_q;
      irq_en_d  = irq_en_q;
      irq_pol_d = irq_pol_q;
      cfg_d     = cfg_q;
      w1c       = '0;
      if (wr) begin
         case (reg_addr)
            GPIO_DOUT:       dout_d    = wdata_n;
            GPIO_OEN:        oen_d     = wdata_n;
            GPIO_IE:         ie_d      = wdata_n;
            GPIO_IRQ_EN:     irq_en_d  = wdata_n;
            GPIO_IRQ_POL:    irq_pol_d = wdata_n;
            GPIO_IRQ_STATUS: w1c       = wdata_n;
            GPIO_DOUT_SET:   dout_d    = dout_q | wdata_n;
            GPIO_DOUT_CLR:   dout_d    = dout_q & ~wdata_n;
            default:         ;
         endcase
         for (int k = 0; k < N; k++)
            if (reg_addr == cfg_addr(k)) cfg_d[k] = reg_wdata[CFGW-1:0];
      end
      // a new event on a bit being cleared keeps that bit set
      status_d = (status_q & ~w1c) | evt;
      irq_d    = |(status_q & irq_en_q);
   end

   always_comb begin
      rdata_mux = '0;
      case (reg_addr)
         GPIO_DOUT:       rdata_mux[N-1:0] = dout_q;
         GPIO_OEN:        rdata_mux[N-1:0] = oen_q;
         GPIO_IE:         rdata_mux[N-1:0] = ie_q;
         GPIO_DIN:        rdata_mux[N-1:0] = din_s;
         GPIO_IRQ_EN:     rdata_mux[N-1:0] = irq_en_q;
         GPIO_IRQ_POL:    rdata_mux[N-1:0] = irq_pol_q;
         GPIO_IRQ_STATUS: rdata_mux[N-1:0] = status_q;
         default:         ;
      endcase
      for (int k = 0; k < N; k++)
         if (reg_addr == cfg_addr(k)) rdata_mux[CFGW-1:0] = cfg_q[k];
      rdata_d  = rd ? rdata_mux : rdata_q;
      rvalid_d = rd;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         dout_q    <= '0;
         oen_q     <= '1;
         ie_q      <= '0;
         ie_prev_q <= '0;
         irq_en_q  <= '0;
         irq_pol_q <= '0;
         status_q  <= '0;
         prev_q    <= '0;
         cfg_q     <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         dout_q    <= dout_d;
         oen_q     <= oen_d;
         ie_q      <= ie_d;
         ie_prev_q <= ie_q;
         irq_en_q  <= irq_en_d;
         irq_pol_q <= irq_pol_d;
         status_q  <= status_d;
         prev_q    <= din_s;
         cfg_q     <= cfg_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         irq_q     <= irq_d;
      end
   end

   assign gpio_dout  = dout_q;
   assign gpio_oen   = oen_q;
   assign gpio_ie    = ie_q;
   assign gpio_cfg   = cfg_q;
   assign reg_rdata  = rdata_q;
   assign reg_rvalid = rvalid_q;
   assign irq        = irq_q;

endmodule
